ccx_mem_arbiter: RTL and testbench

Two-to-one arbiter that shares the single core-complex memory port between the instruction-fetch requester and the data (load/store) requester. Sits in `ccx` between the core's two `core_mem_bus` requester ports and the downstream memory/interconnect `core_mem_bus` responder. It locks ownership for the full duration of a transaction, arbitrates round-robin, and drives `rtype` to tag the winner.

---
 rtl/ccx_mem_arbiter_if.sv | 26 ++
 rtl/ccx_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_ccx_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccx_mem_arbiter_if.sv
// core_mem_bus: one memory request/response port shared by the core.
// REQ drives the request side and RSP drives the response side.
interface core_mem_bus #(
  parameter int AW = 39,
  parameter int DW = 64
);
  logic            req;
  logic            rtype;
  logic [AW-1:0]   addr;
  logic            wen;
  logic [DW/8-1:0] strb;
  logic [DW-1:0]   wdata;
  logic            gnt;
  logic            err;
  logic [DW-1:0]   rdata;

  modport REQ (
    output req, rtype, addr, wen, strb, wdata,
    input  gnt, err, rdata
  );

  modport RSP (
    input  req, rtype, addr, wen, strb, wdata,
    output gnt, err, rdata
  );
endinterface

// File: rtl/ccx_mem_arbiter.sv
// ccx_mem_arbiter: round-robin 2:1 arbiter of imem/dmem onto one memory
// port, holding ownership until the owning transaction completes.
module ccx_mem_arbiter #(
  parameter int AW = 39,
  parameter int DW = 64
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  core_mem_bus.RSP    imem,
  core_mem_bus.RSP    dmem,
  core_mem_bus.REQ    mem,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    OWN_I,
    OWN_D
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            prio;
  logic            prio_nxt;
  logic            own_i;
  logic            own_d;
  logic            o_req;
  logic            o_wen;
  logic [AW-1:0]   o_addr;
  logic [DW/8-1:0] o_strb;
  logic [DW-1:0]   o_wdata;

  // Ownership is decided freshly in IDLE and locked otherwise.
  always_comb begin
    own_i = 1'b0;
    own_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (g_resetn) begin
          if (imem.req && dmem.req) begin
            own_i = !prio;
            own_d = prio;
          end else begin
            own_i = imem.req;
            own_d = dmem.req;
          end
        end
      end
      OWN_I:   own_i = 1'b1;
      OWN_D:   own_d = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    o_req   = 1'b0;
    o_wen   = 1'b0;
    o_addr  = '0;
    o_strb  = '0;
    o_wdata = '0;
    unique case (1'b1)
      own_i: begin
        o_req   = imem.req;
        o_wen   = imem.wen;
        o_addr  = imem.addr;
        o_strb  = imem.strb;
        o_wdata = imem.wdata;
      end
      own_d: begin
        o_req   = dmem.req;
        o_wen   = dmem.wen;
        o_addr  = dmem.addr;
        o_strb  = dmem.strb;
        o_wdata = dmem.wdata;
      end
      default: ;
    endcase
  end

  assign mem.req   = o_req;
  assign mem.rtype = own_d;
  assign mem.addr  = o_addr;
  assign mem.wen   = o_wen;
  assign mem.strb  = o_strb;
  assign mem.wdata = o_wdata;

  assign imem.gnt   = own_i & mem.gnt;
  assign imem.err   = own_i & mem.err;
  assign imem.rdata = mem.rdata;
  assign dmem.gnt   = own_d & mem.gnt;
  assign dmem.err   = own_d & mem.err;
  assign dmem.rdata = mem.rdata;

  assign busy = (state != IDLE) || o_req;

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    if (own_i && mem.gnt) prio_nxt = 1'b1;
    if (own_d && mem.gnt) prio_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (own_i && !mem.gnt)
          state_nxt = OWN_I;
        else if (own_d && !mem.gnt)
          state_nxt = OWN_D;
      end
      OWN_I, OWN_D: begin
        if (mem.gnt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state <= IDLE;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
    end
  end

endmodule

// File: tb/tb_ccx_mem_arbiter.sv
// tb_ccx_mem_arbiter: scoreboard bench for ccx_mem_arbiter with a
// wait-state programmable responder model.
module tb_ccx_mem_arbiter;

  typedef struct {
    bit          port;
    logic [38:0] addr;
    logic        wen;
    logic [7:0]  strb;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  int checks = 0;
  int failures = 0;

  exp_t sbq[$];

  int          i_left = 0;
  logic [38:0] i_addr = '0;
  int          d_left = 0;
  logic [38:0] d_addr = '0;
  logic        d_wen = 1'b0;
  logic [7:0]  d_strb = '0;

  int   waits = 0;
  int   wcnt;
  logic err_en = 1'b0;

  core_mem_bus #(.AW(39), .DW(64)) ibus ();
  core_mem_bus #(.AW(39), .DW(64)) dbus ();
  core_mem_bus #(.AW(39), .DW(64)) mbus ();

  ccx_mem_arbiter #(.AW(39), .DW(64)) dut (
    .g_clk    (clk),
    .g_resetn (rst_n),
    .imem     (ibus.RSP),
    .dmem     (dbus.RSP),
    .mem      (mbus.REQ),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rmodel(input logic [38:0] a);
    return {25'h0, a} ^ 64'h5a5a_0000_0000_1234;
  endfunction

  function automatic logic [63:0] wmodel(input logic [38:0] a);
    return {25'h0, a} + 64'h1;
  endfunction

  assign ibus.req   = i_left > 0;
  assign ibus.rtype = 1'b1;
  assign ibus.addr  = i_addr;
  assign ibus.wen   = 1'b0;
  assign ibus.strb  = '0;
  assign ibus.wdata = '0;

  assign dbus.req   = d_left > 0;
  assign dbus.rtype = 1'b0;
  assign dbus.addr  = d_addr;
  assign dbus.wen   = d_wen;
  assign dbus.strb  = d_strb;
  assign dbus.wdata = wmodel(d_addr);

  always @(posedge clk or negedge rst_n)
    if (!rst_n) wcnt <= 0;
    else if (mbus.req && !mbus.gnt) wcnt <= wcnt + 1;
    else wcnt <= 0;

  assign mbus.gnt   = mbus.req && (wcnt >= waits);
  assign mbus.err   = mbus.gnt && err_en;
  assign mbus.rdata = mbus.gnt ? rmodel(mbus.addr) : '0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (i_left == 0 && d_left == 0) begin
        done = 1'b1;
        break;
      end
      cyc(1);
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
  endtask

  function automatic exp_t mk(input bit p, input logic [38:0] a,
                              input logic w, input logic [7:0] s,
                              input logic e);
    exp_t x;
    x.port = p;
    x.addr = a;
    x.wen  = w;
    x.strb = s;
    x.err  = e;
    return x;
  endfunction

  // Completion monitor: every upstream grant is matched to the queue head.
  always @(negedge clk) begin
    if (rst_n && (ibus.gnt || dbus.gnt)) begin
      exp_t e;
      bit p;
      p = dbus.gnt;
      chk("one_gnt", 64'(ibus.gnt & dbus.gnt), 64'd0);
      if (sbq.size() == 0) begin
        chk("sb_unexpected", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("port", 64'(p), 64'(e.port));
        chk("rtype", 64'(mbus.rtype), 64'(e.port));
        chk("addr", 64'(mbus.addr), 64'(e.addr));
        chk("wen", 64'(mbus.wen), 64'(e.wen));
        chk("strb", 64'(mbus.strb), 64'(e.strb));
        if (e.wen) chk("wdata", mbus.wdata, wmodel(e.addr));
        chk("rdata", p ? dbus.rdata : ibus.rdata, rmodel(e.addr));
        chk("err", 64'(p ? dbus.err : ibus.err), 64'(e.err));
        chk("other_err", 64'(p ? ibus.err : dbus.err), 64'd0);
      end
      @(posedge clk);
      #1;
      if (p) d_left--;
      else i_left--;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_req", 64'(mbus.req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rtype", 64'(mbus.rtype), 64'd0);
    chk("rst_addr", 64'(mbus.addr), 64'd0);
    chk("rst_wdata", mbus.wdata, 64'd0);
    chk("rst_gnt", 64'({ibus.gnt, dbus.gnt, ibus.err, dbus.err}), 64'd0);
    chk("rst_prio", 64'(dut.prio), 64'd0);

    // simultaneous requests from reset: I first then D write
    cyc(1);
    waits = 1;
    i_addr = 39'h80;
    d_addr = 39'h2000;
    d_wen  = 1'b1;
    d_strb = 8'hff;
    sbq.push_back(mk(1'b0, 39'h80, 1'b0, 8'h00, 1'b0));
    sbq.push_back(mk(1'b1, 39'h2000, 1'b1, 8'hff, 1'b0));
    i_left = 1;
    d_left = 1;
    @(negedge clk);
    chk("sim_rtype_c1", 64'(mbus.rtype), 64'd0);
    chk("sim_busy", 64'(busy), 64'd1);
    wait_idle("sim");
    chk("sim_prio", 64'(dut.prio), 64'd0);

    // single instruction read with two wait cycles
    d_wen  = 1'b0;
    d_strb = '0;
    waits  = 2;
    i_addr = 39'h1000;
    sbq.push_back(mk(1'b0, 39'h1000, 1'b0, 8'h00, 1'b0));
    i_left = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("one_rtype", 64'(mbus.rtype), 64'd0);
      chk("one_addr", 64'(mbus.addr), 64'h1000);
      chk("one_dgnt", 64'(dbus.gnt), 64'd0);
      chk("one_ignt", 64'(ibus.gnt), 64'(k == 2));
    end
    wait_idle("one");

    // lock: D owns, I arrives later and must wait
    waits  = 4;
    d_addr = 39'h3000;
    i_addr = 39'h4000;
    sbq.push_back(mk(1'b1, 39'h3000, 1'b0, 8'h00, 1'b0));
    sbq.push_back(mk(1'b0, 39'h4000, 1'b0, 8'h00, 1'b0));
    d_left = 1;
    cyc(1);
    i_left = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d_left == 0) break;
      chk("lock_addr", 64'(mbus.addr), 64'h3000);
    end
    chk("lock_next_addr", 64'(mbus.addr), 64'h4000);
    chk("lock_next_rtype", 64'(mbus.rtype), 64'd0);
    wait_idle("lock");

    // zero-wait responder, both always requesting; prio points at D
    cyc(1);
    waits  = 0;
    i_addr = 39'h100;
    d_addr = 39'h200;
    for (int k = 0; k < 4; k++) begin
      sbq.push_back(mk(1'b1, 39'h200, 1'b0, 8'h00, 1'b0));
      sbq.push_back(mk(1'b0, 39'h100, 1'b0, 8'h00, 1'b0));
    end
    i_left = 4;
    d_left = 4;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("zw_state", 64'(dut.state), 64'd0);
    end
    wait_idle("zw");

    // error response on a D read
    cyc(1);
    waits  = 1;
    err_en = 1'b1;
    d_addr = 39'h2468;
    chk("err_prio_pre", 64'(dut.prio), 64'd1);
    sbq.push_back(mk(1'b1, 39'h2468, 1'b0, 8'h00, 1'b1));
    d_left = 1;
    wait_idle("err");
    err_en = 1'b0;
    chk("err_prio", 64'(dut.prio), 64'd0);

    // reset while D owns, I pending
    i_addr = 39'h7000;
    sbq.push_back(mk(1'b0, 39'h7000, 1'b0, 8'h00, 1'b0));
    i_left = 1;
    wait_idle("pre_rst");
    waits  = 10;
    d_addr = 39'h5000;
    d_left = 1;
    cyc(2);
    i_addr = 39'h6000;
    i_left = 1;
    cyc(1);
    chk("mid_state", 64'(dut.state), 64'd2);
    chk("mid_prio", 64'(dut.prio), 64'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    waits = 1;
    #1;
    chk("mid_rst_req", 64'(mbus.req), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_state", 64'(dut.state), 64'd0);
    sbq.push_back(mk(1'b0, 39'h6000, 1'b0, 8'h00, 1'b0));
    sbq.push_back(mk(1'b1, 39'h5000, 1'b0, 8'h00, 1'b0));
    #1 rst_n = 1'b1;
    wait_idle("post_rst");

    cyc(2);
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
